// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: stepped linear chirp generator for the NCO tuning word.
// One-shot up-sweep or continuous triangle, each word held dwell+1 cycles.
module nco_sweep_ctrl #(
  parameter int STEP_WIDTH  = 9,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                          iclk,
  input  logic                          iresetn,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          mode,
  input  logic signed [STEP_WIDTH-1:0]  step_start,
  input  logic signed [STEP_WIDTH-1:0]  step_stop,
  input  logic        [STEP_WIDTH-2:0]  step_inc,
  input  logic        [DWELL_WIDTH-1:0] dwell,
  output logic signed [STEP_WIDTH-1:0]  step,
  output logic                          busy,
  output logic                          done
);

  localparam int EW = STEP_WIDTH + 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic signed [STEP_WIDTH-1:0]  step_q, step_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          dir_q, dir_d;
  logic        [DWELL_WIDTH-1:0] cnt_q, cnt_d;

  logic                          mode_q, mode_d;
  logic signed [STEP_WIDTH-1:0]  lo_q, lo_d;
  logic signed [STEP_WIDTH-1:0]  hi_q, hi_d;
  logic        [STEP_WIDTH-2:0]  inc_q, inc_d;
  logic        [DWELL_WIDTH-1:0] dwell_q, dwell_d;

  logic signed [EW-1:0] step_x;
  logic signed [EW-1:0] lo_x;
  logic signed [EW-1:0] hi_x;
  logic signed [EW-1:0] inc_x;
  logic signed [EW-1:0] up_sum;
  logic signed [EW-1:0] dn_sum;
  logic signed [STEP_WIDTH-1:0] up_next;
  logic signed [STEP_WIDTH-1:0] dn_next;
  logic at_hi;
  logic at_lo;
  logic degen;

  // Widened advance arithmetic so sums never wrap before clamping.
  always_comb begin
    step_x  = {step_q[STEP_WIDTH-1], step_q};
    lo_x    = {lo_q[STEP_WIDTH-1], lo_q};
    hi_x    = {hi_q[STEP_WIDTH-1], hi_q};
    inc_x   = {2'b00, inc_q};
    up_sum  = step_x + inc_x;
    dn_sum  = step_x - inc_x;
    up_next = (up_sum >= hi_x) ? hi_q : up_sum[STEP_WIDTH-1:0];
    dn_next = (dn_sum <= lo_x) ? lo_q : dn_sum[STEP_WIDTH-1:0];
    at_hi   = (step_x >= hi_x);
    at_lo   = (step_x <= lo_x);
    degen   = (lo_x >= hi_x);
  end

  // Sweep state machine: next state, next word and dwell counter.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    inc_d   = inc_q;
    dwell_d = dwell_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && (step_inc != '0)) begin
          state_d = S_RUN;
          step_d  = step_start;
          cnt_d   = dwell;
          dir_d   = 1'b0;
          busy_d  = 1'b1;
          mode_d  = mode;
          lo_d    = step_start;
          hi_d    = step_stop;
          inc_d   = step_inc;
          dwell_d = dwell;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else begin
          cnt_d = dwell_q;
          if (degen) begin
            // Empty range: stop is reached at once; triangle just parks.
            if (!mode_q) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else if (!dir_q) begin
            if (at_hi) begin
              if (!mode_q) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                dir_d  = 1'b1;
                step_d = dn_next;
              end
            end else begin
              step_d = up_next;
            end
          end else begin
            if (at_lo) begin
              dir_d  = 1'b0;
              step_d = up_next;
            end else begin
              step_d = dn_next;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, outputs and latched sweep configuration.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      inc_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      inc_q   <= inc_d;
      dwell_q <= dwell_d;
    end
  end

  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: scoreboard bench for nco_sweep_ctrl.
// Per-cycle expectations are queued by stimulus and popped on negedge.
module tb_nco_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start = 1'b0;
  logic abort = 1'b0;
  logic mode = 1'b0;
  logic signed [8:0] lo = '0;
  logic signed [8:0] hi = '0;
  logic [7:0] inc = '0;
  logic [15:0] dwell = '0;
  logic signed [8:0] step_a;
  logic busy_a;
  logic done_a;

  logic b_start = 1'b0;
  logic signed [9:0] b_lo = '0;
  logic signed [9:0] b_hi = '0;
  logic [8:0] b_inc = '0;
  logic signed [9:0] step_b;
  logic busy_b;
  logic done_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit sel;
    int step;
    bit busy;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int vals[];

  always #5 clk = ~clk;

  nco_sweep_ctrl u_a (
    .iclk(clk), .iresetn(rst_n),
    .start(start), .abort(abort), .mode(mode),
    .step_start(lo), .step_stop(hi),
    .step_inc(inc), .dwell(dwell),
    .step(step_a), .busy(busy_a), .done(done_a)
  );

  nco_sweep_ctrl #(.STEP_WIDTH(10)) u_b (
    .iclk(clk), .iresetn(rst_n),
    .start(b_start), .abort(abort), .mode(mode),
    .step_start(b_lo), .step_stop(b_hi),
    .step_inc(b_inc), .dwell(dwell),
    .step(step_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Queue this cycle's expected outputs, then advance to the next cycle.
  task automatic cyc(input int s, input bit b, input bit d,
                     input bit sel = 1'b0);
    exp_t e;
    e.sel = sel;
    e.step = s;
    e.busy = b;
    e.done = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int s;
      e = exp_q.pop_front();
      if (e.sel) begin
        s = step_b;
        check("b_step", s, e.step);
        check("b_busy", int'(busy_b), int'(e.busy));
        check("b_done", int'(done_b), int'(e.done));
      end else begin
        s = step_a;
        check("step", s, e.step);
        check("busy", int'(busy_a), int'(e.busy));
        check("done", int'(done_a), int'(e.done));
      end
    end
  end

  initial begin
    int s;
    #12;
    s = step_a;
    check("rst_step", s, 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0);

    // One-shot 10..20 by 4, dwell 2; mid-run start and config changes.
    mode = 0; lo = 10; hi = 20; inc = 4; dwell = 2;
    start = 1; cyc(0, 0, 0); start = 0;
    vals = '{10, 14, 18, 20};
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin
        start = 1; hi = 100; inc = 1; dwell = 0; mode = 1;
      end
      if (i == 5) begin
        start = 0; hi = 20; inc = 4; dwell = 2; mode = 0;
      end
      cyc(vals[i/3], 1, 0);
    end
    // Restart on the done cycle, then abort on the 4th cycle.
    start = 1; cyc(20, 0, 1); start = 0;
    cyc(10, 1, 0); cyc(10, 1, 0); cyc(10, 1, 0);
    abort = 1; cyc(14, 1, 0); abort = 0;
    cyc(14, 0, 0); cyc(14, 0, 0);
    start = 1; cyc(14, 0, 0); start = 0;
    cyc(10, 1, 0);
    abort = 1; cyc(10, 1, 0); abort = 0;
    cyc(10, 0, 0);

    // Abort on the final hold suppresses done.
    lo = 0; hi = 4; dwell = 0;
    start = 1; cyc(10, 0, 0); start = 0;
    cyc(0, 1, 0);
    abort = 1; cyc(4, 1, 0); abort = 0;
    cyc(4, 0, 0); cyc(4, 0, 0);

    // Zero increment is ignored.
    inc = 0;
    start = 1; cyc(4, 0, 0); start = 0;
    cyc(4, 0, 0); cyc(4, 0, 0);

    // Signed range with clamp.
    lo = -100; hi = -90; inc = 7; dwell = 0;
    start = 1; cyc(4, 0, 0); start = 0;
    cyc(-100, 1, 0); cyc(-93, 1, 0); cyc(-90, 1, 0);
    cyc(-90, 0, 1); cyc(-90, 0, 0);

    // Degenerate range, one-shot.
    lo = 5; hi = 5; inc = 3; dwell = 1;
    start = 1; cyc(-90, 0, 0); start = 0;
    cyc(5, 1, 0); cyc(5, 1, 0); cyc(5, 0, 1); cyc(5, 0, 0);

    // Degenerate range, triangle parks until abort.
    mode = 1; lo = 7; hi = 3; dwell = 0;
    start = 1; cyc(5, 0, 0); start = 0;
    for (int i = 0; i < 5; i++) cyc(7, 1, 0);
    abort = 1; cyc(7, 1, 0); abort = 0;
    cyc(7, 0, 0);

    // Wide instance: near full-scale clamp without wrap.
    mode = 0; dwell = 0;
    b_lo = 250; b_hi = 255; b_inc = 255;
    b_start = 1; cyc(0, 0, 0, 1'b1); b_start = 0;
    cyc(250, 1, 0, 1'b1); cyc(255, 1, 0, 1'b1);
    cyc(255, 0, 1, 1'b1); cyc(255, 0, 0, 1'b1);

    // Triangle 0..8 by 4, then asynchronous reset mid-sweep.
    mode = 1; lo = 0; hi = 8; inc = 4; dwell = 0;
    start = 1; cyc(7, 0, 0); start = 0;
    vals = '{0, 4, 8, 4, 0, 4, 8, 4, 0};
    for (int i = 0; i < 9; i++) cyc(vals[i], 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    s = step_a;
    check("arst_step", s, 0);
    check("arst_busy", int'(busy_a), 0);
    check("arst_done", int'(done_a), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep controller that drives the tuning-word (`step`) input of the LUT-based NCO. It generates a stepped linear chirp from a start word to a stop word, holding each word for a programmable dwell. It runs either as a one-shot up-sweep or as a continuous triangle sweep. The block sits directly upstream of the NCO, and its `step` output connects straight to the NCO's `step` port.

## Interface
- `STEP_WIDTH`, default 9: width of the signed tuning word; matches the NCO step port (accumulator size + 1).
- `DWELL_WIDTH`, default 16: width of the dwell counter.
- `iclk`, in, 1: the single clock.
- `iresetn`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: single-cycle request to begin a sweep; sampled only in IDLE.
- `abort`, in, 1: stops a running sweep; has priority over every other event.
- `mode`, in, 1: 0 selects a one-shot up-sweep; 1 selects a continuous triangle sweep.
- `step_start`, in, STEP_WIDTH, signed: first tuning word.
- `step_stop`, in, STEP_WIDTH, signed: final (upper) tuning word.
- `step_inc`, in, STEP_WIDTH-1, unsigned: increment applied per dwell period.
- `dwell`, in, DWELL_WIDTH, unsigned: each word is held for `dwell`+1 cycles.
- `step`, out, STEP_WIDTH, signed, registered: tuning word sent to the NCO.
- `busy`, out, 1, registered: high while a sweep runs.
- `done`, out, 1, registered: one-cycle pulse when a one-shot sweep completes.

## Operation
- Reset values: `step`=0, `busy`=0, `done`=0, state=IDLE, direction=up, dwell counter=0.
- All config inputs (`mode`, `step_start`, `step_stop`, `step_inc`, `dwell`) are latched on an accepted start. Changes to them during a sweep have no effect.
- States:
  - **IDLE:** `start`=1 and `step_inc`≠0 leads to RUN. In that case, `step`←`step_start`, counter←`dwell`, direction←up, `busy`←1. A `start` with `step_inc`=0 is ignored.
  - **RUN:** if the counter is not 0, it decrements. If the counter is 0, the block takes the boundary/advance action below and reloads the counter with `dwell`.
- Advance arithmetic:
  - All sums and compares use STEP_WIDTH+1-bit signed arithmetic, so an intermediate value never wraps.
  - Up: next = `step` + `step_inc`. If next ≥ stop, next is clamped to stop.
  - Down: next = `step` − `step_inc`. If next ≤ start, next is clamped to start.
- Boundaries (evaluated when the counter is 0):
  - Up with `step` = stop, mode 0: go to IDLE, `busy`←0, `done`←1, and `step` holds at stop.
  - Up with `step` = stop, mode 1: direction←down, then apply the down advance.
  - Down with `step` = start: direction←up, then apply the up advance.
- Degenerate range, `step_start` ≥ `step_stop`:
  - The stop word is treated as reached on the first hold.
  - Mode 0: a single hold of `step_start`, then `done`.
  - Mode 1: `step` holds `step_start` until abort.
- `abort`=1 in RUN: next state is IDLE, `busy`←0, no `done`, and `step` holds its current value. `abort` in IDLE has no effect.
- `start` during RUN is ignored.

## Timing
- An accepted start at edge k puts `step_start` on `step` and raises `busy` after edge k, so both are visible in cycle k+1.
- Each word is presented for exactly `dwell`+1 cycles. The next word appears on the edge where the counter is 0.
- One-shot completion:
  - After the final hold of stop, `busy` falls and `done` rises on the same edge.
  - `done` lasts exactly one cycle.
  - A new `start` is accepted on the cycle `done` is high.
- Abort coinciding with the end of the final hold: abort wins and `done` stays 0.
- Asynchronous reset mid-sweep returns all outputs to their reset values immediately. No sweep resumes after reset deasserts.
- Latency from `step` to the NCO output is defined by the NCO and is not this block's concern.

## Test plan
- One-shot: start=10, stop=20, inc=4, dwell=2, mode=0 -> `step` is 10,10,10,14,14,14,18,18,18,20,20,20. Then `done` pulses 1 cycle, `busy` goes to 0, and `step` stays 20.
- Triangle: start=0, stop=8, inc=4, dwell=0, mode=1 -> `step` is 0,4,8,4,0,4,8,… every cycle. `done` never asserts.
- Signed/clamp: start=−100, stop=−90, inc=7, dwell=0, mode=0 -> −100, −93, −90, then `done`. Also start=250, stop=255, inc=255 (STEP_WIDTH=10) -> 250, 255, `done`, with no wrap.
- Abort at the 4th cycle of the one-shot case -> `busy`=0 on the next cycle, `step` holds 14, no `done`. A restart is then accepted.
- Ignored requests: `start` with inc=0 -> stays IDLE with `busy`=0. A second `start` during RUN -> the sequence is unchanged.
- Reset mid-triangle -> `step`=0, `busy`=0, `done`=0 asynchronously, and the block remains idle after release.
